deskew_stream_buffer: RTL and testbench
=======================================

// Module: deskew_stream_buffer
// PURPOSE
//  Parametrised, mode-selectable skew/deskew lane buffer for the systolic array edges.
//  DESKEW mode (MODE=0) realigns skewed column outputs into whole result rows.
//  SKEW mode (MODE=1) staggers aligned rows onto the array inputs.
//  Adds per-lane valid tracking, stall, sync clear, tile row counting and misalignment detection.
// PARAMETERS
//  N          4   lane count (array dimension), >=2
//  WIDTH      32  data bits per lane
//  MODE       0   0=deskew (lane i delayed N-1-i stages), 1=skew (lane i delayed i stages)
//  TILE_ROWS  4   aligned rows per tile, >=2; CW = $clog2(TILE_ROWS)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset (asserted when 0)
//  enable     in   1          advance strobe; 0 = stall, all state holds
//  clr        in   1          synchronous clear of pipeline, valids, counter, error
//  col_input  in   WIDTH x N  lane data, unpacked array [0:N-1]
//  in_valid   in   N          per-lane valid, bit i qualifies col_input[i]
//  col_output out  WIDTH x N  lane data after delay + output register
//  out_valid  out  N          per-lane valid, aligned with col_output
//  row_valid  out  1          one complete row event this cycle (see below)
//  tile_last  out  1          pulses with the row_valid that completes a tile
//  tile_count out  CW         rows completed in current tile, 0..TILE_ROWS-1
//  align_err  out  1          sticky deskew misalignment flag
// BEHAVIOUR
//  - Reset (reset=0): every delay reg, col_output, out_valid, row_valid, tile_last,
//    tile_count, align_err -> 0 immediately; held until reset=1.
//  - Lane i: chain of D(i) regs (D=N-1-i deskew, i skew) then one output reg.
//    Latency in enabled cycles = D(i)+1. Deskew: lane i N-i, lane N-1 1. Skew: lane 0 1, lane N-1 N.
//  - Valid bit travels alongside data in a parallel chain of identical depth.
//  - Data regs load regardless of valid: invalid lanes carry data, valid bit 0.
//  - enable=0: data/valid chains and col_output hold. out_valid, row_valid, tile_last
//    forced 0 that cycle, so a held row is never counted twice. Resume: no loss or duplication.
//  - clr=1 at an edge: all chains, outputs, counter and align_err -> 0; clr beats enable.
//  - Row event, deskew: row_valid=1 when enable and all N output-stage valids are 1.
//  - Row event, skew: row_valid=1 when enable and out_valid[N-1]=1 (last lane emitted).
//  - Misalignment (deskew only): enable, output-stage valids neither all-0 nor all-1.
//    Effect: align_err <= 1 (sticky until clr/reset); row_valid=0; out_valid still per-lane.
//  - Tile counter: on each row event, tile_count increments. At TILE_ROWS-1 it wraps to 0
//    and tile_last=1 in that same cycle (registered together with row_valid).
//  - Simultaneous clr and row event: clr wins; no count, no pulse.
//  - All outputs registered; no combinational path input -> output.
// TESTING (N=4, WIDTH=32, TILE_ROWS=4 unless noted)
//  1 Deskew align: lane i gets 0x10+i, valid, at cycle t0+i
//    -> after edge t0+4: col_output={0x10,0x11,0x12,0x13}, row_valid=1, tile_count=1.
//  2 Skew (MODE=1): all lanes valid at t0 with {A,B,C,D}
//    -> lane i out_valid=1 with its value after edge t0+i+1.
//    -> row_valid only after edge t0+4.
//  3 Stall: 8 rows streamed, enable=0 for 3 cycles mid-stream
//    -> outputs hold, row_valid=0 while stalled; 8 distinct rows total, in order.
//  4 Tile: 4 back-to-back aligned rows
//    -> tile_count 1,2,3,0; tile_last=1 only with 4th row_valid.
//  5 Misalign: lane 2 valid one cycle late
//    -> align_err=1, row_valid=0 for affected rows; align_err held until clr=1 clears to 0.
//  6 Async reset mid-stream (reset=0 between edges)
//    -> all outputs 0 before next edge; clean restart after reset=1.

Source files
------------

// File: rtl/deskew_stream_buffer.sv
// Mode-selectable skew/deskew lane buffer for systolic array edges: per-lane delay
// chains with parallel valid chains, stall/clear control, tile row counting, misalign flag.
module deskew_stream_buffer #(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int MODE      = 0,
    parameter int TILE_ROWS = 4,
    localparam int CW       = $clog2(TILE_ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic [WIDTH-1:0] col_input  [0:N-1],
    input  logic [N-1:0]     in_valid,
    output logic [WIDTH-1:0] col_output [0:N-1],
    output logic [N-1:0]     out_valid,
    output logic             row_valid,
    output logic             tile_last,
    output logic [CW-1:0]    tile_count,
    output logic             align_err
);

    logic [WIDTH-1:0] w_tail_d [0:N-1];
    logic [N-1:0]     w_tail_v;
    logic             w_row;
    logic             w_mis;
    logic             w_wrap;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int D = (MODE == 0) ? (N - 1 - gi) : gi;

        if (D == 0) begin : g_direct
            assign w_tail_d[gi] = col_input[gi];
            assign w_tail_v[gi] = in_valid[gi];
        end else begin : g_chain
            logic [WIDTH-1:0] r_d [0:D-1];
            logic [D-1:0]     r_v;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned k = 0; k < D; k++) r_d[k] <= '0;
                    r_v <= '0;
                end else if (clr) begin
                    for (int unsigned k = 0; k < D; k++) r_d[k] <= '0;
                    r_v <= '0;
                end else if (enable) begin
                    r_d[0] <= col_input[gi];
                    r_v[0] <= in_valid[gi];
                    for (int unsigned k = 1; k < D; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end

            assign w_tail_d[gi] = r_d[D-1];
            assign w_tail_v[gi] = r_v[D-1];
        end
    end

    // Row/misalign decisions use the valids about to enter the output stage,
    // so the flags register in the same edge as the data they describe.
    always_comb begin
        w_row = 1'b0;
        w_mis = 1'b0;
        if (MODE == 0) begin
            w_row = &w_tail_v;
            w_mis = (|w_tail_v) && !(&w_tail_v);
        end else begin
            w_row = w_tail_v[N-1];
        end
    end

    assign w_wrap = (tile_count == CW'(TILE_ROWS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) col_output[i] <= '0;
            out_valid  <= '0;
            row_valid  <= 1'b0;
            tile_last  <= 1'b0;
            tile_count <= '0;
            align_err  <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < N; i++) col_output[i] <= '0;
            out_valid  <= '0;
            row_valid  <= 1'b0;
            tile_last  <= 1'b0;
            tile_count <= '0;
            align_err  <= 1'b0;
        end else if (enable) begin
            for (int unsigned i = 0; i < N; i++) col_output[i] <= w_tail_d[i];
            out_valid <= w_tail_v;
            row_valid <= w_row;
            tile_last <= w_row && w_wrap;
            if (w_row) tile_count <= w_wrap ? '0 : tile_count + 1'b1;
            if (w_mis) align_err <= 1'b1;
        end else begin
            // Stalled: data holds but event strobes drop so a held row is not recounted.
            out_valid <= '0;
            row_valid <= 1'b0;
            tile_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deskew_stream_buffer.sv
// Scoreboard bench for deskew_stream_buffer: one deskew and one skew instance,
// directed stimulus pushes expected rows, negedge monitors pop and compare.
module tb_deskew_stream_buffer;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic [1:0]     tc;
        logic           last;
    } exp_t;

    typedef struct packed {
        logic [1:0] tc;
        logic       last;
    } srow_t;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         d_en, d_clr;
    logic [W-1:0] d_in  [0:N-1];
    logic [N-1:0] d_vin;
    logic [W-1:0] d_out [0:N-1];
    logic [N-1:0] d_out_valid;
    logic         d_row_valid, d_tile_last, d_align_err;
    logic [1:0]   d_tile_count;

    logic         s_en, s_clr;
    logic [W-1:0] s_in  [0:N-1];
    logic [N-1:0] s_vin;
    logic [W-1:0] s_out [0:N-1];
    logic [N-1:0] s_out_valid;
    logic         s_row_valid, s_tile_last, s_align_err;
    logic [1:0]   s_tile_count;

    exp_t           dq [$];
    logic [N*W-1:0] sq [$];
    srow_t          srq [$];
    int             s_ptr [N];

    int n_checks = 0;
    int n_fail   = 0;
    int tc_model = 0;
    int s_tc     = 0;

    always #5 clk = ~clk;

    deskew_stream_buffer #(.N(N), .WIDTH(W), .MODE(0), .TILE_ROWS(4)) u_deskew (
        .clk(clk), .reset(rst_n), .enable(d_en), .clr(d_clr),
        .col_input(d_in), .in_valid(d_vin),
        .col_output(d_out), .out_valid(d_out_valid), .row_valid(d_row_valid),
        .tile_last(d_tile_last), .tile_count(d_tile_count), .align_err(d_align_err)
    );

    deskew_stream_buffer #(.N(N), .WIDTH(W), .MODE(1), .TILE_ROWS(4)) u_skew (
        .clk(clk), .reset(rst_n), .enable(s_en), .clr(s_clr),
        .col_input(s_in), .in_valid(s_vin),
        .col_output(s_out), .out_valid(s_out_valid), .row_valid(s_row_valid),
        .tile_last(s_tile_last), .tile_count(s_tile_count), .align_err(s_align_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane i carries row (c-i) at stream cycle c, so each row enters skewed.
    task automatic drive_deskew(input int c, input int nrows, input logic [W-1:0] base, input bit push);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int r;
            r = c - i;
            if (r >= 0 && r < nrows) begin
                d_in[i]  = base + W'(r * 16 + i);
                d_vin[i] = 1'b1;
            end else begin
                d_in[i]  = 32'hDEAD_0000 + W'(c);
                d_vin[i] = 1'b0;
            end
        end
        if (push && c < nrows) begin
            for (int i = 0; i < N; i++) e.data[i*W +: W] = base + W'(c * 16 + i);
            tc_model = (tc_model == 3) ? 0 : tc_model + 1;
            e.tc   = 2'(tc_model);
            e.last = (tc_model == 0);
            dq.push_back(e);
        end
    endtask

    task automatic idle_deskew(input int n);
        d_en = 1'b1;
        d_vin = '0;
        for (int i = 0; i < N; i++) d_in[i] = 32'h0BAD_0000 + W'(i);
        repeat (n) tick();
    endtask

    task automatic deskew_rows(input int nrows, input logic [W-1:0] base, input int stall_at, input int stall_len);
        int c = 0;
        int stalled = 0;
        while (c < nrows + N - 1) begin
            if (c == stall_at && stalled < stall_len) begin
                d_en  = 1'b0;
                d_vin = '1;
                for (int i = 0; i < N; i++) d_in[i] = 32'hBAD0_0000 + W'(i);
                tick();
                stalled++;
                chk("stall_row_valid", 64'(d_row_valid), 64'(0));
                chk("stall_out_valid", 64'(d_out_valid), 64'(0));
            end else begin
                d_en = 1'b1;
                drive_deskew(c, nrows, base, 1'b1);
                tick();
                c++;
            end
        end
        idle_deskew(N + 1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N; i++) chk({tag, "_col_output"}, 64'(d_out[i]), 64'(0));
        chk({tag, "_out_valid"},  64'(d_out_valid),  64'(0));
        chk({tag, "_row_valid"},  64'(d_row_valid),  64'(0));
        chk({tag, "_tile_last"},  64'(d_tile_last),  64'(0));
        chk({tag, "_tile_count"}, 64'(d_tile_count), 64'(0));
        chk({tag, "_align_err"},  64'(d_align_err),  64'(0));
    endtask

    // Deskew monitor: every row event must match the next queued row.
    always @(negedge clk) begin
        if (d_row_valid) begin
            if (dq.size() == 0) begin
                chk("deskew_unexpected_row", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = dq.pop_front();
                for (int i = 0; i < N; i++)
                    chk($sformatf("deskew_row_lane%0d", i), 64'(d_out[i]), 64'(e.data[i*W +: W]));
                chk("deskew_row_out_valid",  64'(d_out_valid),  64'(4'hF));
                chk("deskew_row_tile_count", 64'(d_tile_count), 64'(e.tc));
                chk("deskew_row_tile_last",  64'(d_tile_last),  64'(e.last));
            end
        end
    end

    // Skew monitor: lanes emit independently, row events carry the tile count.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (s_out_valid[i]) begin
                if (s_ptr[i] >= sq.size()) begin
                    chk($sformatf("skew_unexpected_lane%0d", i), 64'(1), 64'(0));
                end else begin
                    chk($sformatf("skew_lane%0d", i), 64'(s_out[i]), 64'(sq[s_ptr[i]][i*W +: W]));
                    s_ptr[i]++;
                end
            end
        end
        if (s_row_valid) begin
            if (srq.size() == 0) begin
                chk("skew_unexpected_row", 64'(1), 64'(0));
            end else begin
                srow_t r;
                r = srq.pop_front();
                chk("skew_row_tile_count", 64'(s_tile_count), 64'(r.tc));
                chk("skew_row_tile_last",  64'(s_tile_last),  64'(r.last));
            end
        end
    end

    task automatic skew_push(input logic [N*W-1:0] row);
        srow_t r;
        sq.push_back(row);
        s_tc = (s_tc == 3) ? 0 : s_tc + 1;
        r.tc   = 2'(s_tc);
        r.last = (s_tc == 0);
        srq.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] row;
        for (int i = 0; i < N; i++) s_ptr[i] = 0;
        rst_n = 1'b0;
        d_en = 1'b1; d_clr = 1'b0; d_vin = '0;
        s_en = 1'b1; s_clr = 1'b0; s_vin = '0;
        for (int i = 0; i < N; i++) begin
            d_in[i] = '0;
            s_in[i] = '0;
        end

        // Reset state
        #12;
        check_all_zero("reset");
        chk("reset_skew_out_valid", 64'(s_out_valid), 64'(0));
        rst_n = 1'b1;
        tick();

        // Single skewed row realigns four edges after lane 0 enters
        for (int c = 0; c < N; c++) begin
            drive_deskew(c, 1, 32'h10, 1'b1);
            tick();
            chk($sformatf("align_out_valid_c%0d", c), 64'(d_out_valid), 64'((c == 3) ? 4'hF : 4'h0));
            chk($sformatf("align_row_valid_c%0d", c), 64'(d_row_valid), 64'(c == 3));
        end
        idle_deskew(1);
        chk("align_row_valid_after", 64'(d_row_valid), 64'(0));
        chk("align_tile_count_hold", 64'(d_tile_count), 64'(1));

        // clr at the edge that would complete a row: no event, counter cleared
        for (int c = 0; c < N; c++) begin
            drive_deskew(c, 1, 32'h40, 1'b0);
            d_clr = (c == 3);
            tick();
        end
        d_clr = 1'b0;
        tc_model = 0;
        chk("clr_row_valid",  64'(d_row_valid),  64'(0));
        chk("clr_tile_count", 64'(d_tile_count), 64'(0));
        idle_deskew(N + 1);

        // Tile wrap: four back-to-back rows
        deskew_rows(4, 32'h100, -1, 0);

        // Stall mid-stream: eight rows, three stalled cycles
        deskew_rows(8, 32'h200, 5, 3);

        // Misalignment: lane 2 one cycle late
        for (int c = 0; c < 6; c++) begin
            d_en = 1'b1;
            for (int i = 0; i < N; i++) begin
                d_in[i]  = 32'h600 + W'(i);
                d_vin[i] = (i == 2) ? (c == 3) : (c == i);
            end
            tick();
            if (c == 2) chk("mis_err_before", 64'(d_align_err), 64'(0));
            if (c == 3) begin
                chk("mis_out_valid_a", 64'(d_out_valid), 64'(4'b1011));
                chk("mis_err_a",       64'(d_align_err), 64'(1));
            end
            if (c == 4) begin
                chk("mis_out_valid_b", 64'(d_out_valid), 64'(4'b0100));
                chk("mis_err_b",       64'(d_align_err), 64'(1));
            end
        end
        idle_deskew(3);
        chk("mis_err_sticky", 64'(d_align_err), 64'(1));
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        chk("mis_err_cleared", 64'(d_align_err), 64'(0));
        tc_model = 0;

        // Skew: one aligned row staggers out lane by lane
        s_en = 1'b1;
        s_vin = '1;
        for (int i = 0; i < N; i++) begin
            s_in[i] = 32'hA000_0000 + W'(i);
            row[i*W +: W] = s_in[i];
        end
        skew_push(row);
        for (int k = 1; k <= N + 1; k++) begin
            tick();
            s_vin = '0;
            for (int i = 0; i < N; i++) s_in[i] = 32'h0F0F_0000;
            chk($sformatf("skew_out_valid_e%0d", k), 64'(s_out_valid), 64'((k <= N) ? (4'b1 << (k - 1)) : 4'b0));
            chk($sformatf("skew_row_valid_e%0d", k), 64'(s_row_valid), 64'(k == N));
        end

        // Skew: four back-to-back rows through the tile wrap
        for (int c = 0; c < 4; c++) begin
            s_vin = '1;
            for (int i = 0; i < N; i++) begin
                s_in[i] = 32'h5000_0000 + W'(c * 16 + i);
                row[i*W +: W] = s_in[i];
            end
            skew_push(row);
            tick();
        end
        s_vin = '0;
        repeat (N + 2) tick();

        // Async reset between edges mid-stream
        for (int c = 0; c < 5; c++) begin
            d_en = 1'b1;
            drive_deskew(c, 3, 32'h300, 1'b1);
            tick();
        end
        chk("pre_reset_tile_count", 64'(d_tile_count), 64'(2));
        d_vin = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        dq.delete();
        tc_model = 0;
        tick();
        check_all_zero("reset_held");
        #2 rst_n = 1'b1;
        deskew_rows(1, 32'h400, -1, 0);
        chk("restart_tile_count", 64'(d_tile_count), 64'(1));

        repeat (2) tick();
        chk("deskew_queue_drained", 64'(dq.size()), 64'(0));
        chk("skew_rows_drained",    64'(srq.size()), 64'(0));
        for (int i = 0; i < N; i++)
            chk($sformatf("skew_lane%0d_drained", i), 64'(s_ptr[i]), 64'(sq.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
